// File: rtl/seq_divider8x4_pkg.sv
// Shared types and widths for the sequential 8/4 restoring divider.
// DIVIDEND_W also sets the iteration count, one quotient bit per cycle.
package div_pkg;
  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  localparam logic [DIVIDEND_W-1:0] QUOT_DZ = '1;
  localparam logic [DIVISOR_W-1:0]  REM_DZ  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_divider8x4_if.sv
// Start/busy/done request bus of the divider: operands in, results out.
interface seq_divider8x4_if;
  import div_pkg::*;

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider8x4_div_step.sv
// One combinational restoring step, built on a bitwise ripple-carry subtractor
// so the cell can later be replaced by a reversible implementation.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W:0]   pr,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   pr_next,
  output logic                 q_bit
);
  localparam int PW = DIVISOR_W + 1;

  logic [PW-1:0] shifted;
  logic [PW-1:0] sub_b;
  logic [PW-1:0] diff;
  logic [PW:0]   carry;

  assign shifted  = {pr[DIVISOR_W-1:0], dividend_bit};
  assign sub_b    = ~{1'b0, divisor};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < PW; i++) begin : g_sub
    assign diff[i]    = shifted[i] ^ sub_b[i] ^ carry[i];
    assign carry[i+1] = (shifted[i] & sub_b[i]) | (carry[i] & (shifted[i] ^ sub_b[i]));
  end

  // A set pr MSB means the true shifted value exceeds PW bits, so it always covers the divisor.
  assign q_bit   = pr[DIVISOR_W] | carry[PW];
  assign pr_next = q_bit ? diff : shifted;
endmodule

// File: rtl/seq_divider8x4.sv
// Sequential restoring divider: FSM, iteration counter and the combined
// dividend/quotient shift register around one div_step cell.
module seq_divider8x4
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  seq_divider8x4_if.slave  bus
);
  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dq_sh;
  logic [DIVISOR_W-1:0]  dsr;
  logic [DIVISOR_W:0]    pr;
  logic [DIVISOR_W:0]    step_pr;
  logic                  step_q;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  dz;
  logic                  accept;
  logic                  last_step;

  assign accept    = bus.start && (state != CALC);
  assign last_step = (state == CALC) && (cnt == '0);

  div_step u_step (
    .pr           (pr),
    .dividend_bit (dq_sh[DIVIDEND_W-1]),
    .divisor      (dsr),
    .pr_next      (step_pr),
    .q_bit        (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept)             state_nx = (bus.divisor == '0) ? DONE : CALC;
        else if (state == DONE) state_nx = IDLE;
      end
      CALC:    if (last_step) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      dq_sh     <= '0;
      dsr       <= '0;
      pr        <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
    end else if (accept) begin
      cnt   <= CNT_W'(DIVIDEND_W - 1);
      dq_sh <= bus.dividend;
      dsr   <= bus.divisor;
      pr    <= '0;
      dz    <= 1'b0;
      if (bus.divisor == '0) begin
        quotient  <= QUOT_DZ;
        remainder <= REM_DZ;
        dz        <= 1'b1;
      end
    end else if (state == CALC) begin
      cnt   <= cnt - 1'b1;
      pr    <= step_pr;
      dq_sh <= {dq_sh[DIVIDEND_W-2:0], step_q};
      if (last_step) begin
        quotient  <= {dq_sh[DIVIDEND_W-2:0], step_q};
        remainder <= step_pr[DIVISOR_W-1:0];
      end
    end
  end

  assign bus.busy        = (state == CALC);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = dz;
endmodule

// File: doc/seq_divider8x4.md
Name: seq_divider8x4

Overview:
Sequential restoring divider that computes an 8-bit dividend divided by a 4-bit divisor. It returns the quotient and remainder. It is the inverse operation of the 4x4 Vedic multiplier datapath: for any product it produces, dividing by one factor returns the other. It sits in the matrix-multiplier datapath for normalisation/scaling and for self-checking of multiplier results. It produces one quotient bit per clock, with a start/busy/done handshake.

Parameters:
DIVIDEND_W, 8, dividend and quotient width; iteration count = DIVIDEND_W
DIVISOR_W, 4, divisor and remainder width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
dividend  input  DIVIDEND_W  numerator; captured on accepted start
divisor  input  DIVISOR_W  denominator; captured on accepted start
busy  output  1  high while iterating (CALC state)
done  output  1  single-cycle pulse; results valid from this cycle
quotient  output  DIVIDEND_W  result, held until next accepted start
remainder  output  DIVISOR_W  result, held until next accepted start
div_by_zero  output  1  set with done when captured divisor==0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n, and overrides everything, including mid-operation.
  - On reset: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0, internal registers=0.
  - After reset deasserts, the first accepted start behaves normally.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 with divisor!=0: capture operands, clear the partial remainder, load counter=DIVIDEND_W-1, go to CALC.
  - start=1 with divisor==0: go to DONE directly.
    - quotient={DIVIDEND_W{1}}, remainder={DIVISOR_W{1}}, div_by_zero=1.
    - done asserts the next cycle (latency 1).
- CALC, one restoring step per cycle, MSB first:
  - pr' = {pr[DIVISOR_W-1:0], dividend_bit}, where pr is the (DIVISOR_W+1)-bit partial remainder.
  - If pr' >= {1'b0, divisor}: pr=pr'-divisor and q_bit=1. Otherwise pr=pr' and q_bit=0.
  - The quotient shift register takes q_bit into its LSB.
  - Counter decrements. When counter==0 this cycle, go to DONE.
  - start is ignored throughout CALC.
- DONE:
  - Lasts exactly one cycle.
  - done=1; quotient, remainder and div_by_zero are updated in the same edge as entry to DONE.
  - start=1 in DONE is accepted as in IDLE, giving a back-to-back operation; otherwise go to IDLE.
- Latency: start accepted at edge N, so busy=1 over cycles N+1..N+DIVIDEND_W, and done=1 in cycle N+DIVIDEND_W+1.
- Throughput: one division per DIVIDEND_W+1 cycles.
- Output stability:
  - quotient, remainder and div_by_zero only change on entry to DONE (or on reset).
  - div_by_zero clears on the next accepted start.
- Arithmetic: the partial remainder is kept at DIVISOR_W+1 bits so the compare never overflows. The final remainder is pr[DIVISOR_W-1:0], which is always < divisor.
- Inputs dividend and divisor may change freely after capture without affecting an operation in flight.
- busy and done are never high together.

Decomposition:
- Shared package div_pkg:
  - state enum {IDLE, CALC, DONE}
  - localparams DIVIDEND_W, DIVISOR_W, CNT_W = $clog2(DIVIDEND_W)
  - zero-divide result constants QUOT_DZ and REM_DZ
- One natural sub-module: div_step.
  - Purely combinational, one restoring iteration.
  - Inputs: pr, dividend_bit, divisor. Outputs: next pr, q_bit.
  - Built on the codebase's reversible ripple-carry subtractor style, so the step can be swapped for a reversible implementation later.
- The top module holds the FSM, counter and operand/quotient shift registers.

Test Plan:
- Basic division: dividend=200, divisor=7, start pulse. Required: done exactly 9 cycles after the start edge, quotient=28, remainder=4, div_by_zero=0, busy high for 8 cycles.
- Edge operands:
  - 255/1 gives q=255, r=0.
  - 5/9 gives q=0, r=5.
  - 0/15 gives q=0, r=0.
  - 225/15 gives q=15, r=0 (the inverse of the multiplier's 15x15).
- Divide by zero: divisor=0, dividend=77. Required: done on the cycle after start, quotient=8'hFF, remainder=4'hF, div_by_zero=1. A following 10/3 returns q=3, r=1 and div_by_zero=0.
- Handshake:
  - Change operands and pulse start during CALC of 100/6. The extra start is ignored, and the result is still q=16, r=4.
  - start held high in DONE launches the next operation with no IDLE cycle.
- Reset mid-operation: assert rst_n low at cycle 4 of CALC, asynchronously between edges. All outputs go to 0 immediately. After release, 81/9 gives q=9, r=0.
- Exhaustive check: for all dividend in 0..255 and divisor in 1..15, quotient*divisor+remainder==dividend and remainder<divisor. Cross-check with vedic4x4_mult for every dividend <= 225 whose quotient fits in 4 bits.
